// File: rtl/fwrisc_regfile_ctrl.sv
// Register-file access controller: clears the reset-less register array after reset,
// then passes core accesses through and serves single-word debug reads/writes when the core is idle.
module fwrisc_regfile_ctrl #(
    parameter int                NUM_REGS   = 64,
    parameter int                ADDR_W     = 6,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_ra_raddr,
    input  logic [ADDR_W-1:0] core_rb_raddr,
    input  logic [ADDR_W-1:0] core_rd_waddr,
    input  logic [DATA_W-1:0] core_rd_wdata,
    input  logic              core_rd_wen,
    input  logic              core_idle,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ra_raddr,
    output logic [ADDR_W-1:0] rb_raddr,
    output logic [ADDR_W-1:0] rd_waddr,
    output logic [DATA_W-1:0] rd_wdata,
    output logic              rd_wen,
    input  logic [DATA_W-1:0] ra_rdata
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DBG_RD  = 2'd2,
        ST_DBG_ACK = 2'd3
    } state_e;

    // One extra counter bit keeps the terminal compare from wrapping to zero.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              core_stall_q, core_stall_d;
    logic              rd_wen_s;

    // Next-state, port muxing and register-file drive.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_rdata_d = dbg_rdata_q;
        ra_raddr    = core_ra_raddr;
        rd_waddr    = core_rd_waddr;
        rd_wdata    = core_rd_wdata;
        rd_wen_s    = core_rd_wen;
        case (state_q)
            ST_INIT: begin
                rd_wen_s = 1'b1;
                rd_waddr = init_cnt_q[ADDR_W-1:0];
                rd_wdata = INIT_VALUE;
                if (init_cnt_q == LAST_IDX) begin
                    init_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (dbg_req && core_idle && !core_rd_wen) begin
                    dbg_addr_d = dbg_addr;
                    if (dbg_we) begin
                        rd_wen_s = 1'b1;
                        rd_waddr = dbg_addr;
                        rd_wdata = dbg_wdata;
                        state_d  = ST_DBG_ACK;
                    end else begin
                        ra_raddr = dbg_addr;
                        state_d  = ST_DBG_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBG_RD: begin
                ra_raddr    = dbg_addr_q;
                rd_wen_s    = 1'b0;
                dbg_rdata_d = ra_rdata;
                state_d     = ST_DBG_ACK;
            end
            ST_DBG_ACK: begin
                rd_wen_s = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                rd_wen_s = 1'b0;
                state_d  = ST_INIT;
            end
        endcase
        dbg_ack_d    = (state_d == ST_DBG_ACK);
        core_stall_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            dbg_addr_q   <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
            core_stall_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            dbg_addr_q   <= dbg_addr_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_rdata_q  <= dbg_rdata_d;
            core_stall_q <= core_stall_d;
        end
    end

    // No register-file write may escape while reset is held.
    assign rd_wen     = rd_wen_s & reset;
    assign rb_raddr   = core_rb_raddr;
    assign core_stall = core_stall_q;
    assign dbg_ack    = dbg_ack_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_fwrisc_regfile_ctrl.sv
// Self-checking bench for fwrisc_regfile_ctrl with a behavioural register file and
// a shadow-memory reference model of the architectural register contents.
module tb_fwrisc_regfile_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  core_ra_raddr, core_rb_raddr, core_rd_waddr;
    logic [31:0] core_rd_wdata;
    logic        core_rd_wen, core_idle, core_stall;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
    logic [31:0] rd_wdata, ra_rdata;
    logic        rd_wen;

    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [64];

    logic [31:0] ref_mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];

    fwrisc_regfile_ctrl dut (
        .clock(clock), .reset(reset),
        .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
        .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
        .core_rd_wen(core_rd_wen), .core_idle(core_idle), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ra_raddr(ra_raddr), .rb_raddr(rb_raddr), .rd_waddr(rd_waddr),
        .rd_wdata(rd_wdata), .rd_wen(rd_wen), .ra_rdata(ra_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural register file: synchronous read, entry 0 reads as zero.
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (rd_wen) mem[rd_waddr] <= rd_wdata;
        ra_rdata <= (ra_raddr == 6'd0) ? 32'd0 : mem[ra_raddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [5:0] a);
        return (a == 6'd0) ? 32'd0 : ref_mem[a];
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_clear();
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            chk("clr_wen", 32'(rd_wen), 32'd1);
            chk("clr_waddr", 32'(rd_waddr), 32'(i));
            chk("clr_wdata", rd_wdata, 32'd0);
            chk("clr_stall", 32'(core_stall), 32'd1);
            next_cycle();
        end
        @(negedge clock);
        chk("clr_done_stall", 32'(core_stall), 32'd0);
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        next_cycle();
    endtask

    task automatic core_read(input logic [5:0] a, input logic [31:0] exp, input string nm);
        core_ra_raddr = a;
        @(negedge clock);
        chk("core_ra_pass", 32'(ra_raddr), 32'(a));
        next_cycle();
        @(negedge clock);
        chk(nm, ra_rdata, exp);
        core_ra_raddr = 6'd1;
        next_cycle();
    endtask

    task automatic dbg_txn(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (dbg_ack) begin
                lat = c;
                rd  = dbg_rdata;
                break;
            end
            if (c == 0 && we) begin
                chk("grant_wen", 32'(rd_wen), 32'd1);
                chk("grant_waddr", 32'(rd_waddr), 32'(addr));
                chk("grant_wdata", rd_wdata, wd);
            end
            if (c == 0 && !we) chk("grant_raddr", 32'(ra_raddr), 32'(addr));
            if (c == 1 && !we) begin
                chk("rd_hold_raddr", 32'(ra_raddr), 32'(addr));
                chk("rd_stall", 32'(core_stall), 32'd1);
                chk("rd_no_wen", 32'(rd_wen), 32'd0);
            end
            next_cycle();
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: no dbg_ack within 40 cycles, addr %0d", addr);
        end
        dbg_req = 1'b0;
        next_cycle();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          acks;
        int          exp_ack [6];

        vecs[0] = '{1'b1, 6'd10, 32'h12345678, 32'h00000000, 1};
        vecs[1] = '{1'b0, 6'd10, 32'h00000000, 32'h12345678, 2};
        vecs[2] = '{1'b1, 6'd0,  32'hFFFFFFFF, 32'h12345678, 1};
        vecs[3] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 2};
        vecs[4] = '{1'b1, 6'd63, 32'hCAFEF00D, 32'h00000000, 1};
        vecs[5] = '{1'b0, 6'd5,  32'h00000000, 32'h00000000, 2};
        vecs[6] = '{1'b0, 6'd63, 32'h00000000, 32'hCAFEF00D, 2};
        exp_ack = '{0, 1, 0, 1, 0, 0};

        reset = 1'b0;
        core_ra_raddr = 6'd1; core_rb_raddr = 6'd2; core_rd_waddr = 6'd0;
        core_rd_wdata = 32'd0; core_rd_wen = 1'b0; core_idle = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 6'd0; dbg_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 6'd0; pl_data = 32'd0;

        // Power-on reset and first clear.
        repeat (2) begin
            @(negedge clock);
            chk("rst_stall", 32'(core_stall), 32'd1);
            chk("rst_ack", 32'(dbg_ack), 32'd0);
            chk("rst_wen", 32'(rd_wen), 32'd0);
            chk("rst_rdata", dbg_rdata, 32'd0);
        end
        next_cycle();
        reset = 1'b1;
        check_clear();
        chk("rb_pass", 32'(rb_raddr), 32'(core_rb_raddr));

        // Pre-load stale data, then reset must clear it again.
        pl_en = 1'b1; pl_addr = 6'd5; pl_data = 32'hDEADBEEF;
        next_cycle();
        pl_addr = 6'd63;
        next_cycle();
        pl_en = 1'b0;
        core_read(6'd5, 32'hDEADBEEF, "preload_5");
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("rst2_wen", 32'(rd_wen), 32'd0);
            chk("rst2_stall", 32'(core_stall), 32'd1);
            next_cycle();
        end
        reset = 1'b1;
        check_clear();
        core_read(6'd5, 32'd0, "cleared_5");
        core_read(6'd63, 32'd0, "cleared_63");

        // Table-driven debug transactions.
        for (int i = 0; i < 7; i++) begin
            dbg_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, rd, lat);
            chk("tbl_lat", 32'(lat), 32'(vecs[i].exp_lat));
            chk("tbl_rdata", rd, vecs[i].exp_rd);
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wd;
        end

        // Core priority: debug waits while the core writes.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd3; dbg_wdata = 32'h0BADF00D;
        core_rd_wen = 1'b1; core_rd_waddr = 6'd4; core_rd_wdata = 32'hA5A5A5A5;
        repeat (4) begin
            @(negedge clock);
            chk("prio_wen", 32'(rd_wen), 32'd1);
            chk("prio_waddr", 32'(rd_waddr), 32'd4);
            chk("prio_wdata", rd_wdata, 32'hA5A5A5A5);
            chk("prio_ack", 32'(dbg_ack), 32'd0);
            next_cycle();
        end
        core_rd_wen = 1'b0;
        ref_mem[4] = 32'hA5A5A5A5;
        dbg_txn(1'b1, 6'd3, 32'h0BADF00D, rd, lat);
        chk("prio_lat", 32'(lat), 32'd1);
        ref_mem[3] = 32'h0BADF00D;
        dbg_txn(1'b0, 6'd4, 32'd0, rd, lat);
        chk("prio_rd4", rd, 32'hA5A5A5A5);
        dbg_txn(1'b0, 6'd3, 32'd0, rd, lat);
        chk("prio_rd3", rd, 32'h0BADF00D);

        // Held request: back-to-back writes, one ack each, 2 cycles apart.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd20; dbg_wdata = 32'h11111111;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("held_ack", 32'(dbg_ack), 32'(exp_ack[c]));
            if (dbg_ack) acks++;
            if (c == 2) begin
                chk("held_waddr2", 32'(rd_waddr), 32'd21);
                chk("held_wen2", 32'(rd_wen), 32'd1);
            end
            if (c == 1) begin dbg_addr = 6'd21; dbg_wdata = 32'h22222222; end
            if (c == 3) dbg_req = 1'b0;
            next_cycle();
        end
        chk("held_ack_count", 32'(acks), 32'd2);
        ref_mem[20] = 32'h11111111;
        ref_mem[21] = 32'h22222222;
        dbg_txn(1'b0, 6'd20, 32'd0, rd, lat);
        chk("held_rd20", rd, 32'h11111111);
        dbg_txn(1'b0, 6'd21, 32'd0, rd, lat);
        chk("held_rd21", rd, 32'h22222222);

        // Reset in DBG_RD: no ack, read data cleared, clear restarts at 0.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd10;
        @(negedge clock);
        chk("mid_grant", 32'(ra_raddr), 32'd10);
        next_cycle();
        reset = 1'b0;
        dbg_req = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("mid_ack", 32'(dbg_ack), 32'd0);
            chk("mid_rdata", dbg_rdata, 32'd0);
            chk("mid_stall", 32'(core_stall), 32'd1);
            chk("mid_wen", 32'(rd_wen), 32'd0);
            next_cycle();
        end
        reset = 1'b1;
        check_clear();
        core_read(6'd10, 32'd0, "mid_cleared_10");

        // Randomised traffic against the shadow-memory model.
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [5:0]  a;
            logic [31:0] wd;
            int          k;
            we = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 63));
            wd = $urandom;
            k  = $urandom_range(0, 3);
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
            for (int c = 0; c < k; c++) begin
                core_idle     = 1'($urandom_range(0, 1));
                core_rd_wen   = core_idle ? 1'b1 : 1'($urandom_range(0, 1));
                core_rd_waddr = 6'($urandom_range(1, 63));
                core_rd_wdata = $urandom;
                @(negedge clock);
                chk("rnd_blk_ack", 32'(dbg_ack), 32'd0);
                chk("rnd_blk_stall", 32'(core_stall), 32'd0);
                chk("rnd_blk_wen", 32'(rd_wen), 32'(core_rd_wen));
                if (core_rd_wen) ref_mem[core_rd_waddr] = core_rd_wdata;
                next_cycle();
            end
            core_idle = 1'b1;
            core_rd_wen = 1'b0;
            dbg_txn(we, a, wd, rd, lat);
            chk("rnd_lat", 32'(lat), we ? 32'd1 : 32'd2);
            if (we) ref_mem[a] = wd;
            else chk("rnd_rdata", rd, ref_read(a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
